// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for pong; serve delay, rally, point award and game over.
// Optional build macro WIN_BY_TWO_EN: a game needs a two-point lead, and deuce scores are pulled back.
module pong_match_ctrl #(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       score_checker1,
   input  logic       score_checker2,
   output logic       ball_enable,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] player1_score,
   output logic [3:0] player2_score,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state_code
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SERVE_WAIT = 3'd1,
      ST_PLAY       = 3'd2,
      ST_POINT      = 3'd3,
      ST_GAME_OVER  = 3'd4
   } state_t;

   localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       p1_reg, p1_next;
   logic [3:0]       p2_reg, p2_next;
   logic             serve_dir_reg, serve_dir_next;
   logic             winner_reg, winner_next;
   logic [2:0]       in_vec, in_q_reg, ev;
   logic             p1_wins, p2_wins, deuce;

   // bit 0 = start, bit 1 = player1 scored, bit 2 = player2 scored
   assign in_vec = {score_checker2, score_checker1, start};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_edge
         assign ev[gi] = in_vec[gi] & ~in_q_reg[gi];
      end
   endgenerate

`ifdef WIN_BY_TWO_EN
   assign p1_wins = (p1_reg >= WIN) && ({1'b0, p1_reg} >= ({1'b0, p2_reg} + 5'd2));
   assign p2_wins = (p2_reg >= WIN) && ({1'b0, p2_reg} >= ({1'b0, p1_reg} + 5'd2));
   assign deuce   = (p1_reg == (WIN - 4'd1)) && (p2_reg == (WIN - 4'd1));
`else
   assign p1_wins = (p1_reg == WIN);
   assign p2_wins = (p2_reg == WIN);
   assign deuce   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         p1_reg        <= '0;
         p2_reg        <= '0;
         serve_dir_reg <= 1'b0;
         winner_reg    <= 1'b0;
         in_q_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         p1_reg        <= p1_next;
         p2_reg        <= p2_next;
         serve_dir_reg <= serve_dir_next;
         winner_reg    <= winner_next;
         in_q_reg      <= in_vec;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      p1_next        = p1_reg;
      p2_next        = p2_reg;
      serve_dir_next = serve_dir_reg;
      winner_next    = winner_reg;
      case (state_reg)
         ST_IDLE: begin
            if (ev[0]) begin
               state_next     = ST_SERVE_WAIT;
               cnt_next       = '0;
               p1_next        = '0;
               p2_next        = '0;
               serve_dir_next = 1'b0;
            end
         end
         ST_SERVE_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next   = '0;
               state_next = ST_PLAY;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_PLAY: begin
            // the next serve goes toward whoever conceded the point
            case (ev[2:1])
               2'b01: begin
                  if (p1_reg < WIN) p1_next = p1_reg + 4'd1;
                  serve_dir_next = 1'b1;
                  state_next     = ST_POINT;
               end
               2'b10: begin
                  if (p2_reg < WIN) p2_next = p2_reg + 4'd1;
                  serve_dir_next = 1'b0;
                  state_next     = ST_POINT;
               end
               2'b11: begin
                  cnt_next   = '0;
                  state_next = ST_SERVE_WAIT;
               end
               default: ;
            endcase
         end
         ST_POINT: begin
            cnt_next = '0;
            if (p1_wins || p2_wins) begin
               winner_next = p2_wins;
               state_next  = ST_GAME_OVER;
            end else begin
               if (deuce) begin
                  p1_next = WIN - 4'd2;
                  p2_next = WIN - 4'd2;
               end
               state_next = ST_SERVE_WAIT;
            end
         end
         ST_GAME_OVER: begin
            if (ev[0]) begin
               state_next     = ST_SERVE_WAIT;
               cnt_next       = '0;
               p1_next        = '0;
               p2_next        = '0;
               serve_dir_next = ~winner_reg;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign ball_enable   = (state_reg == ST_PLAY);
   assign ball_reset    = (state_reg == ST_SERVE_WAIT);
   assign game_over     = (state_reg == ST_GAME_OVER);
   assign state_code    = state_reg;
   assign player1_score = p1_reg;
   assign player2_score = p2_reg;
   assign serve_dir     = serve_dir_reg;
   assign winner        = winner_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl (WIN_SCORE=3, SERVE_DELAY=4); one scoreboard check per clock.
module tb_pong_match_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SW    = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_GO    = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       score_checker1 = 1'b0;
   logic       score_checker2 = 1'b0;
   logic       ball_enable, ball_reset, serve_dir, game_over, winner;
   logic [3:0] player1_score, player2_score;
   logic [2:0] state_code;

   pong_match_ctrl #(
      .WIN_SCORE  (3),
      .SERVE_DELAY(4),
      .CNT_W      (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .score_checker1(score_checker1),
      .score_checker2(score_checker2),
      .ball_enable   (ball_enable),
      .ball_reset    (ball_reset),
      .serve_dir     (serve_dir),
      .player1_score (player1_score),
      .player2_score (player2_score),
      .game_over     (game_over),
      .winner        (winner),
      .state_code    (state_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // expected values after the next clock edge
   logic [2:0] e_st;
   logic [3:0] e_p1, e_p2;
   logic       e_dir, e_win;

   task automatic tick(input logic r, input logic s, input logic c1, input logic c2, input string tag);
      exp_t        e;
      logic [15:0] obs;
      e.tag = tag;
      e.v   = {e_st, e_p1, e_p2, e_dir, e_win, (e_st == S_PLAY), (e_st == S_SW), (e_st == S_GO)};
      sb.push_back(e);
      reset          = r;
      start          = s;
      score_checker1 = c1;
      score_checker2 = c2;
      @(posedge clk);
      @(negedge clk);
      obs = {state_code, player1_score, player2_score, serve_dir, winner,
             ball_enable, ball_reset, game_over};
      e = sb.pop_front();
      n_checks++;
      assert (obs === e.v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
      $display("step %-18s st=%0d p1=%0d p2=%0d dir=%0b win=%0b", e.tag, state_code,
               player1_score, player2_score, serve_dir, winner);
   endtask

   // remaining serve delay after the SERVE_WAIT entry edge, ending in PLAY
   task automatic serve_rest(input logic c1, input logic c2, input string tag);
      e_st = S_SW;
      repeat (3) tick(1'b0, 1'b0, c1, c2, tag);
      e_st = S_PLAY;
      tick(1'b0, 1'b0, c1, c2, tag);
   endtask

   // who=0: player1 scores, who=1: player2 scores; nxt is the state after POINT
   task automatic point(input logic who, input logic [2:0] nxt, input logic drop, input string tag);
      e_st = S_POINT;
      if (who) e_p2 = e_p2 + 4'd1;
      else     e_p1 = e_p1 + 4'd1;
      e_dir = ~who;
      tick(1'b0, 1'b0, ~who, who, tag);
      if (nxt == S_GO) begin
         e_st  = S_GO;
         e_win = who;
         tick(1'b0, 1'b0, 1'b0, 1'b0, tag);
      end else begin
         if (drop) begin
            e_p1 = 4'd1;
            e_p2 = 4'd1;
         end
         e_st = S_SW;
         tick(1'b0, 1'b0, 1'b0, 1'b0, tag);
         serve_rest(1'b0, 1'b0, tag);
      end
   endtask

   initial begin
      e_st = S_IDLE; e_p1 = 4'd0; e_p2 = 4'd0; e_dir = 1'b0; e_win = 1'b0;
      tick(1'b1, 1'b1, 1'b0, 1'b0, "reset_a");
      tick(1'b1, 1'b1, 1'b0, 1'b0, "reset_b");
      tick(1'b0, 1'b0, 1'b0, 1'b0, "idle_hold");

      // start edge, four serve-wait cycles, start held has no further effect
      e_st = S_SW;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "start_edge");
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, "serve_wait");
      e_st = S_PLAY;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "release");
      tick(1'b0, 1'b1, 1'b0, 1'b0, "start_held");

      // player1 level held for 10 cycles scores once
      e_st = S_POINT; e_p1 = 4'd1; e_dir = 1'b1;
      tick(1'b0, 1'b0, 1'b1, 1'b0, "p1_point");
      e_st = S_SW;
      repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0, "p1_held_serve");
      e_st = S_PLAY;
      repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0, "p1_held_play");
      tick(1'b0, 1'b0, 1'b0, 1'b0, "p1_release");

      // simultaneous edges: let
      e_st = S_SW;
      tick(1'b0, 1'b0, 1'b1, 1'b1, "let");
      serve_rest(1'b0, 1'b0, "let_serve");

      // player2 wins 1-3
      point(1'b1, S_SW, 1'b0, "p2_a");
      point(1'b1, S_SW, 1'b0, "p2_b");
      point(1'b1, S_GO, 1'b0, "p2_win");
      tick(1'b0, 1'b0, 1'b1, 1'b0, "go_ignore_p1");
      tick(1'b0, 1'b0, 1'b0, 1'b1, "go_ignore_p2");
      e_st = S_SW; e_p1 = 4'd0; e_p2 = 4'd0; e_dir = 1'b0;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "restart_a");
      serve_rest(1'b0, 1'b0, "restart_a_serve");

      // player1 wins 3-0
      point(1'b0, S_SW, 1'b0, "p1_a");
      point(1'b0, S_SW, 1'b0, "p1_b");
      point(1'b0, S_GO, 1'b0, "p1_win");
      e_st = S_SW; e_p1 = 4'd0; e_p2 = 4'd0; e_dir = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "restart_b");
      serve_rest(1'b0, 1'b0, "restart_b_serve");

`ifdef WIN_BY_TWO_EN
      // 2-2 in POINT drops to 1-1, then 3-1 wins
      point(1'b0, S_SW, 1'b0, "wb2_10");
      point(1'b1, S_SW, 1'b0, "wb2_11");
      point(1'b0, S_SW, 1'b0, "wb2_21");
      point(1'b1, S_SW, 1'b1, "wb2_deuce");
      point(1'b0, S_SW, 1'b0, "wb2_21b");
      point(1'b0, S_GO, 1'b0, "wb2_win");
      e_st = S_SW; e_p1 = 4'd0; e_p2 = 4'd0; e_dir = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "wb2_restart");
      serve_rest(1'b0, 1'b0, "wb2_restart_serve");
`endif

      // reset during the serve delay with a point on the board
      e_st = S_POINT; e_p1 = 4'd1; e_dir = 1'b1;
      tick(1'b0, 1'b0, 1'b1, 1'b0, "pre_reset_point");
      e_st = S_SW;
      tick(1'b0, 1'b0, 1'b1, 1'b0, "pre_reset_serve");
      e_st = S_IDLE; e_p1 = 4'd0; e_p2 = 4'd0; e_dir = 1'b0; e_win = 1'b0;
      tick(1'b1, 1'b1, 1'b1, 1'b0, "mid_reset_a");
      tick(1'b1, 1'b1, 1'b1, 1'b0, "mid_reset_b");
      tick(1'b0, 1'b0, 1'b1, 1'b0, "post_reset");
      e_st = S_SW;
      tick(1'b0, 1'b1, 1'b0, 1'b0, "post_reset_start");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
